// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//
// Shared definitions for the UART datapath blocks.
//   OSR_DEFAULT     - default oversample ticks per bit
//   DIV_MIN         - smallest legal oversample period in clk cycles
//   baud_div_t      - integer/fractional divisor pair
//   baud_div_reset  - reset divisor from clock and baud rate:
//                     int  = clk_freq / (baud_rate * osr), truncated
//                     frac = floor(remainder * 2^frac_w / (baud_rate * osr))
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int OSR_DEFAULT = 16;
  localparam int DIV_MIN     = 2;

  typedef struct packed {
    logic [31:0] div_int;
    logic [31:0] div_frac;
  } baud_div_t;

  function automatic baud_div_t baud_div_reset(input int unsigned clk_freq,
                                               input int unsigned baud_rate,
                                               input int unsigned osr,
                                               input int unsigned frac_w);
    longint unsigned den;
    longint unsigned rem;
    baud_div_t       r;
    den        = longint'(baud_rate) * longint'(osr);
    r.div_int  = 32'(longint'(clk_freq) / den);
    rem        = longint'(clk_freq) % den;
    r.div_frac = 32'((rem << frac_w) / den);
    return r;
  endfunction

endpackage

// File: rtl/uart_frac_acc.sv
// -----------------------------------------------------------------------------
// uart_frac_acc
//
// Fractional phase accumulator for the baud generator. On each advance strobe
// the fractional divisor is added to the accumulator; the carry out of that
// addition is held until the next advance and lengthens the following
// oversample period by one clk cycle. Clear has priority over advance.
//
// Only compiled when BAUD_FRAC_EN is defined.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   adv_i       - advance strobe (one per oversample tick)
//   clr_i       - synchronous clear of accumulator and carry
//   frac_i      - fractional divisor, units of 2^-FRAC_W cycles
//   acc_o       - accumulator value
//   cy_o        - carry from the most recent advance
// -----------------------------------------------------------------------------
`ifdef BAUD_FRAC_EN
module uart_frac_acc #(
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv_i,
  input  logic              clr_i,
  input  logic [FRAC_W-1:0] frac_i,
  output logic [FRAC_W-1:0] acc_o,
  output logic              cy_o
);

  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              cy_q, cy_d;

  always_comb begin
    acc_d = acc_q;
    cy_d  = cy_q;
    if (clr_i) begin
      acc_d = '0;
      cy_d  = 1'b0;
    end else if (adv_i) begin
      {cy_d, acc_d} = {1'b0, acc_q} + {1'b0, frac_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cy_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cy_q  <= cy_d;
    end
  end

  assign acc_o = acc_q;
  assign cy_o  = cy_q;

endmodule
`endif

// File: rtl/uart_baud_gen_frac.sv
// -----------------------------------------------------------------------------
// uart_baud_gen_frac
//
// Programmable fractional-N baud generator. Produces an oversample tick for
// the receiver plus mid-bit and bit-boundary ticks derived from it. The
// oversample period is P = max(act_int, 2) + cy, where cy is the carry of a
// fractional accumulator, so the average period is act_int + act_frac/2^FRAC_W.
//
// Configuration macro: BAUD_FRAC_EN
//   defined   - fractional accumulator present (uart_frac_acc instantiated)
//   undefined - integer-only divider, div_frac ignored, cy treated as 0
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   en         - count enable; low freezes counter, accumulator and index
//   div_int    - integer oversample period in clk cycles (0/1 clamp to 2)
//   div_frac   - fractional part, units of 2^-FRAC_W cycles
//   div_load   - strobe capturing div_int/div_frac into the pending divisor
//   sync_clr   - strobe restarting the tick phase
//   os_tick    - one-cycle oversample tick
//   mid_tick   - one-cycle tick at oversample index OSR/2
//   bit_tick   - one-cycle tick at bit boundary
// -----------------------------------------------------------------------------
module uart_baud_gen_frac
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int OSR       = OSR_DEFAULT,
  parameter int DIV_W     = 16,
  parameter int FRAC_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  input  logic              sync_clr,
  output logic              os_tick,
  output logic              mid_tick,
  output logic              bit_tick
);

  localparam int OSI_W = $clog2(OSR);

  localparam baud_div_t        RST_DIV  = baud_div_reset(CLK_FREQ, BAUD_RATE, OSR, FRAC_W);
  localparam logic [DIV_W-1:0] RST_INT  = RST_DIV.div_int[DIV_W-1:0];
  localparam logic [OSI_W-1:0] MID_IDX  = OSI_W'(OSR / 2 - 1);
  localparam logic [OSI_W-1:0] LAST_IDX = OSI_W'(OSR - 1);

  // Active and pending divisor.
  logic [DIV_W-1:0]  act_int_q, act_int_d;
  logic [DIV_W-1:0]  pend_int_q, pend_int_d;
  logic              pend_q, pend_d;

  // Period counter, oversample index and registered ticks.
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [OSI_W-1:0]  osi_q, osi_d;
  logic              os_tick_q, os_tick_d;
  logic              mid_tick_q, mid_tick_d;
  logic              bit_tick_q, bit_tick_d;

  logic              cy;
  logic [DIV_W-1:0]  eff_int;
  logic [DIV_W:0]    per_m1;
  logic              period_end;
  logic              tick_edge;

`ifdef BAUD_FRAC_EN
  localparam logic [FRAC_W-1:0] RST_FRAC = RST_DIV.div_frac[FRAC_W-1:0];

  logic [FRAC_W-1:0] act_frac_q, act_frac_d;
  logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;
  logic [FRAC_W-1:0] acc;

  // The accumulator advances with the active fraction on the tick edge, so
  // the carry it produces stretches the period that starts on that edge.
  uart_frac_acc #(
    .FRAC_W (FRAC_W)
  ) u_frac_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .adv_i  (tick_edge),
    .clr_i  (sync_clr),
    .frac_i (act_frac_q),
    .acc_o  (acc),
    .cy_o   (cy)
  );
`else
  logic unused_div_frac;

  assign cy              = 1'b0;
  assign unused_div_frac = ^div_frac;
`endif

  // Effective period minus one, one bit wider so max(act_int,2)+cy never
  // overflows.
  assign eff_int = (act_int_q < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : act_int_q;
  assign per_m1  = {1'b0, eff_int} + {{DIV_W{1'b0}}, cy} - (DIV_W + 1)'(1);

  // ">=" rather than "==": a divisor shortened while en is low can leave cnt
  // past the new end, and this closes the period at once instead of letting
  // cnt run around its full range.
  assign period_end = ({1'b0, cnt_q} >= per_m1);
  assign tick_edge  = en && !sync_clr && period_end;

  // Period counter, oversample index and tick generation.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch can
    // leave it unassigned and infer a latch.
    cnt_d      = cnt_q;
    osi_d      = osi_q;
    os_tick_d  = 1'b0;
    mid_tick_d = 1'b0;
    bit_tick_d = 1'b0;
    if (sync_clr) begin
      cnt_d = '0;
      osi_d = '0;
    end else if (tick_edge) begin
      cnt_d      = '0;
      osi_d      = osi_q + OSI_W'(1);
      os_tick_d  = 1'b1;
      mid_tick_d = (osi_q == MID_IDX);
      bit_tick_d = (osi_q == LAST_IDX);
    end else if (en) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  // Divisor update. A pending value is normally promoted on a tick edge so the
  // running period finishes with the old divisor; when counting is frozen or
  // the phase is being restarted there is no period to protect, so the newest
  // value (a coincident load wins) goes straight to active.
  always_comb begin
    act_int_d  = act_int_q;
    pend_int_d = pend_int_q;
    pend_d     = pend_q;
`ifdef BAUD_FRAC_EN
    act_frac_d  = act_frac_q;
    pend_frac_d = pend_frac_q;
`endif
    if ((div_load || pend_q) && (sync_clr || !en)) begin
      act_int_d = div_load ? div_int : pend_int_q;
`ifdef BAUD_FRAC_EN
      act_frac_d = div_load ? div_frac : pend_frac_q;
`endif
      pend_d = 1'b0;
    end else begin
      if (pend_q && tick_edge) begin
        act_int_d = pend_int_q;
`ifdef BAUD_FRAC_EN
        act_frac_d = pend_frac_q;
`endif
        pend_d = 1'b0;
      end
      if (div_load) begin
        pend_int_d = div_int;
`ifdef BAUD_FRAC_EN
        pend_frac_d = div_frac;
`endif
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      act_int_q  <= RST_INT;
      pend_int_q <= '0;
      pend_q     <= 1'b0;
      cnt_q      <= '0;
      osi_q      <= '0;
      os_tick_q  <= 1'b0;
      mid_tick_q <= 1'b0;
      bit_tick_q <= 1'b0;
    end else begin
      act_int_q  <= act_int_d;
      pend_int_q <= pend_int_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      osi_q      <= osi_d;
      os_tick_q  <= os_tick_d;
      mid_tick_q <= mid_tick_d;
      bit_tick_q <= bit_tick_d;
    end
  end

`ifdef BAUD_FRAC_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_frac_q  <= RST_FRAC;
      pend_frac_q <= '0;
    end else begin
      act_frac_q  <= act_frac_d;
      pend_frac_q <= pend_frac_d;
    end
  end

  // The accumulator value itself only matters through its carry.
  logic unused_acc;
  assign unused_acc = ^acc;
`endif

  assign os_tick  = os_tick_q;
  assign mid_tick = mid_tick_q;
  assign bit_tick = bit_tick_q;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// -----------------------------------------------------------------------------
// tb_uart_baud_gen_frac
//
// Directed bench for uart_baud_gen_frac at default parameters
// (50 MHz, 9600 baud, OSR 16 -> reset divisor 325). Expected periods are
// hand-computed; fractional expectations switch on BAUD_FRAC_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_baud_gen_frac;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        div_load;
  logic        sync_clr;
  logic        os_tick;
  logic        mid_tick;
  logic        bit_tick;

  int vectors     = 0;
  int miscompares = 0;

  uart_baud_gen_frac dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .div_int  (div_int),
    .div_frac (div_frac),
    .div_load (div_load),
    .sync_clr (sync_clr),
    .os_tick  (os_tick),
    .mid_tick (mid_tick),
    .bit_tick (bit_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled 1 ns after the rising edge; inputs change there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count edges until the selected tick (0 os, 1 mid, 2 bit) is seen.
  // Returns -1 if the budget expires.
  task automatic count_until(input int sel, input int budget, output int n);
    logic hit;
    hit = 1'b0;
    n   = 0;
    while (!hit && n < budget) begin
      step();
      n++;
      hit = (sel == 0) ? os_tick : (sel == 1) ? mid_tick : bit_tick;
    end
    if (!hit) n = -1;
  endtask

  // Load a divisor together with sync_clr: restart with the new value.
  task automatic set_div(input int i, input int f);
    div_int  = 16'(i);
    div_frac = 4'(f);
    div_load = 1'b1;
    sync_clr = 1'b1;
    en       = 1'b1;
    step();
    div_load = 1'b0;
    sync_clr = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst_n    = 1'b0;
    en       = 1'b1;
    div_int  = 16'd0;
    div_frac = 4'd0;
    div_load = 1'b0;
    sync_clr = 1'b0;
    #2;
    vectors++;
    if ({os_tick, mid_tick, bit_tick} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected 000", {os_tick, mid_tick, bit_tick});
    end
    step();
    rst_n = 1'b1;
    count_until(0, 400, n);
    vectors++;
    if (n !== 325) begin
      miscompares++;
      $display("FAIL reset_first_period: got %0d expected 325", n);
    end
    step();
    vectors++;
    if (os_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL os_tick_one_cycle: got %b expected 0", os_tick);
    end
  endtask

  task automatic test_integer();
    int os_cnt = 0, mid_cnt = 0, bit_cnt = 0;
    int misplaced = 0, orphan = 0, mid_first = 0, bit_first = 0;
    set_div(4, 0);
    for (int c = 1; c <= 128; c++) begin
      step();
      if (os_tick) begin
        os_cnt++;
        if (c % 4 != 0) misplaced++;
      end
      if (mid_tick) begin
        mid_cnt++;
        if (mid_first == 0) mid_first = c;
      end
      if (bit_tick) begin
        bit_cnt++;
        if (bit_first == 0) bit_first = c;
      end
      if ((mid_tick || bit_tick) && !os_tick) orphan++;
    end
    vectors++;
    if (os_cnt !== 32) begin miscompares++; $display("FAIL int_os_count: got %0d expected 32", os_cnt); end
    vectors++;
    if (misplaced !== 0) begin miscompares++; $display("FAIL int_os_spacing: got %0d off-grid expected 0", misplaced); end
    vectors++;
    if (mid_first !== 32) begin miscompares++; $display("FAIL int_mid_first: got %0d expected 32", mid_first); end
    vectors++;
    if (mid_cnt !== 2) begin miscompares++; $display("FAIL int_mid_count: got %0d expected 2", mid_cnt); end
    vectors++;
    if (bit_first !== 64) begin miscompares++; $display("FAIL int_bit_first: got %0d expected 64", bit_first); end
    vectors++;
    if (bit_cnt !== 2) begin miscompares++; $display("FAIL int_bit_count: got %0d expected 2", bit_cnt); end
    vectors++;
    if (orphan !== 0) begin miscompares++; $display("FAIL int_tick_coincide: got %0d orphans expected 0", orphan); end
  endtask

  task automatic test_frac();
    int n, total, exp_total;
`ifdef BAUD_FRAC_EN
    exp_total = 72;  // steady periods alternate 4,5
`else
    exp_total = 64;  // fraction ignored
`endif
    set_div(4, 8);
    count_until(0, 50, n);
    vectors++;
    if (n !== 4) begin miscompares++; $display("FAIL frac_first_period: got %0d expected 4", n); end
    total = 0;
    for (int k = 0; k < 16; k++) begin
      count_until(0, 50, n);
      total = (n < 0 || total < 0) ? -1 : total + n;
    end
    vectors++;
    if (total !== exp_total) begin
      miscompares++;
      $display("FAIL frac_16_ticks: got %0d expected %0d", total, exp_total);
    end
  endtask

  task automatic test_load_mid();
    int n;
    set_div(6, 0);
    step();
    step();
    // cnt = 2 here; the load lands on the edge that moves cnt to 3.
    div_int  = 16'd10;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    count_until(0, 50, n);
    vectors++;
    if (n + 3 !== 6) begin miscompares++; $display("FAIL load_old_period: got %0d expected 6", n + 3); end
    count_until(0, 50, n);
    vectors++;
    if (n !== 10) begin miscompares++; $display("FAIL load_new_period1: got %0d expected 10", n); end
    count_until(0, 50, n);
    vectors++;
    if (n !== 10) begin miscompares++; $display("FAIL load_new_period2: got %0d expected 10", n); end
  endtask

  task automatic test_enable();
    int n, frozen;
    set_div(8, 0);
    step();
    step();
    step();
    en     = 1'b0;
    frozen = 0;
    for (int c = 0; c < 7; c++) begin
      step();
      if (os_tick || mid_tick || bit_tick) frozen++;
    end
    vectors++;
    if (frozen !== 0) begin miscompares++; $display("FAIL en_low_ticks: got %0d expected 0", frozen); end
    en = 1'b1;
    // cnt held at 3: P-3 = 5 enabled edges remain (P-4 after the first one).
    count_until(0, 50, n);
    vectors++;
    if (n !== 5) begin miscompares++; $display("FAIL en_resume_period: got %0d expected 5", n); end
  endtask

  task automatic test_sync_clr();
    int n;
    set_div(5, 0);
    count_until(0, 50, n);
    for (int c = 0; c < 4; c++) step();
    // cnt = 4 = P-1: the next edge would be a tick edge.
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    vectors++;
    if (os_tick !== 1'b0) begin miscompares++; $display("FAIL sync_clr_suppress: got %b expected 0", os_tick); end
    count_until(0, 50, n);
    vectors++;
    if (n !== 5) begin miscompares++; $display("FAIL sync_clr_first: got %0d expected 5", n); end
    // osi restarted at 0: mid tick on the 8th os tick, 40 edges after clear.
    count_until(1, 100, n);
    vectors++;
    if (n + 5 !== 40) begin miscompares++; $display("FAIL sync_clr_osi: got %0d expected 40", n + 5); end
  endtask

  task automatic test_clamp();
    int n;
    for (int d = 0; d < 2; d++) begin
      set_div(d, 0);
      count_until(0, 20, n);
      vectors++;
      if (n !== 2) begin miscompares++; $display("FAIL clamp_div%0d_first: got %0d expected 2", d, n); end
      count_until(0, 20, n);
      vectors++;
      if (n !== 2) begin miscompares++; $display("FAIL clamp_div%0d_next: got %0d expected 2", d, n); end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    set_div(6, 0);
    div_int  = 16'd9;
    div_load = 1'b1;
    step();
    div_int  = 16'd3;
    step();
    div_load = 1'b0;
    count_until(0, 50, n);
    vectors++;
    if (n + 2 !== 6) begin miscompares++; $display("FAIL b2b_old_period: got %0d expected 6", n + 2); end
    count_until(0, 50, n);
    vectors++;
    if (n !== 3) begin miscompares++; $display("FAIL b2b_last_wins: got %0d expected 3", n); end
  endtask

  task automatic test_reset_mid();
    int n;
    set_div(4, 0);
    for (int c = 0; c < 4; c++) count_until(0, 20, n);
    // os_tick is high now; reset asynchronously between edges.
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({os_tick, mid_tick, bit_tick} !== 3'b000) begin
      miscompares++;
      $display("FAIL async_reset_outputs: got %b expected 000", {os_tick, mid_tick, bit_tick});
    end
    step();
    step();
    rst_n = 1'b1;
    count_until(0, 400, n);
    vectors++;
    if (n !== 325) begin miscompares++; $display("FAIL async_reset_period: got %0d expected 325", n); end
  endtask

  initial begin
    test_reset();
    test_integer();
    test_frac();
    test_load_mid();
    test_enable();
    test_sync_clr();
    test_clamp();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_baud_gen_frac.md
# uart_baud_gen_frac

Programmable fractional-N baud generator for the UART datapath; successor to the fixed-divisor tick generator. It produces an oversample tick for the receiver, and a bit tick and mid-bit tick derived from it. The divisor is runtime-loadable with a fractional part, and the tick phase can be restarted synchronously. It sits between the register interface and the uart TX/RX engines.

## Interface
- CLK_FREQ, 50_000_000, input clock in Hz; used only for the reset divisor.
- BAUD_RATE, 9600, reset baud rate.
- OSR, 16, oversample ticks per bit; power of two, 4..32.
- DIV_W, 16, integer divisor width.
- FRAC_W, 4, fractional divisor width.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  count enable; low freezes all state.
- div_int  in  DIV_W  integer part of oversample period, in clk cycles.
- div_frac  in  FRAC_W  fractional part, in units of 2^-FRAC_W cycles.
- div_load  in  1  one-cycle strobe that captures div_int/div_frac.
- sync_clr  in  1  one-cycle strobe that restarts the phase (RX start-bit alignment).
- os_tick  out  1  one-cycle oversample tick.
- mid_tick  out  1  one-cycle tick at mid-bit (os index OSR/2).
- bit_tick  out  1  one-cycle tick at bit boundary.

## Operation
- State:
  - active divisor (act_int, act_frac);
  - pending divisor plus a pend flag;
  - period counter cnt (DIV_W bits);
  - fractional accumulator acc (FRAC_W bits) with carry flag cy;
  - oversample index osi (log2 OSR bits).
- Reset: act_int = CLK_FREQ/(BAUD_RATE*OSR), truncated. act_frac = floor of the remainder scaled by 2^FRAC_W. cnt, acc, cy, osi and pend = 0. All outputs = 0.
- Effective period P = max(act_int, 2) + cy. div_int values 0 and 1 are clamped to 2.
- Each clk edge with en=1:
  - If cnt == P-1: cnt <= 0, os_tick <= 1, {cy, acc} <= acc + act_frac, osi <= osi+1 (wraps).
  - Otherwise: cnt <= cnt+1, os_tick <= 0.
- bit_tick <= 1 on the os_tick edge where osi wraps OSR-1 -> 0.
- mid_tick <= 1 on the os_tick edge where osi goes OSR/2-1 -> OSR/2.
- Average oversample period is act_int + act_frac/2^FRAC_W cycles.
- en=0: cnt, acc, cy and osi hold; all three ticks are 0 from the next edge. Resume continues mid-period.
- div_load: captures the inputs into pending and sets pend.
  - The pending value moves to active on the next os_tick edge, or on the same edge if en=0 or sync_clr=1.
  - The period in progress therefore always completes with its old divisor.
- sync_clr: next edge sets cnt, acc, cy and osi to 0 and clears all ticks.
  - The first os_tick follows P cycles later.
  - sync_clr wins over a coincident tick.
  - sync_clr together with div_load: the restart uses the new divisor.
- Back-to-back div_load: the last one wins.
- Asynchronous reset mid-operation returns everything to reset values immediately. No tick is emitted on release.

## Timing
- All outputs are registered; no combinational input-to-output path.
- With en held high from reset release, os_tick is first high for one cycle after exactly P enabled edges, then every P cycles.
- bit_tick and mid_tick coincide with os_tick; each is high for exactly one cycle.
- First bit_tick: after OSR os_ticks. First mid_tick: after OSR/2 os_ticks.
- Divisor change latency is at most one oversample period.

## Configuration
- BAUD_FRAC_EN defined: the fractional accumulator is present as described.
- BAUD_FRAC_EN undefined:
  - acc, cy and act_frac are removed; cy is treated as 0.
  - div_frac is ignored; P = max(act_int, 2).
  - The reset divisor is integer-truncated only.

## Structure
- Shared package uart_pkg holds:
  - the OSR default;
  - the divisor reset-value function (CLK_FREQ, BAUD_RATE, OSR, FRAC_W -> int, frac);
  - the minimum-divisor constant (2).
- One natural sub-module, uart_frac_acc: FRAC_W accumulator with carry-out, advance strobe and clear. It is compiled in only under BAUD_FRAC_EN.

## Test plan
- div_int=4, div_frac=0, OSR=16, en high -> os_tick every 4 cycles, mid_tick at 32 cycles, bit_tick every 64 cycles.
- div_int=4, div_frac=8, FRAC_W=4 -> periods alternate 4,5; 16 os_ticks in 72 cycles. With BAUD_FRAC_EN undefined -> 64 cycles.
- div_load of 10 at cnt=2 under div_int=6 -> current period ends at 6 cycles, following periods are 10.
- en low for 7 cycles at cnt=3 -> no ticks; after re-enable the next tick arrives P-4 cycles later. sync_clr during a tick cycle -> tick suppressed, first os_tick P cycles later, osi = 0.
- div_int=0 and div_int=1 -> os_tick every 2 cycles.
- rst_n low mid-bit -> outputs 0 at once; after release, os_tick after the reset divisor period (325 for defaults).
